serial_operand_feeder: RTL and testbench

SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

---
 rtl/serial_operand_feeder.sv | 138 +++++++++++++
 tb/tb_serial_operand_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: accepts {a,b,op} commands, shifts {a,b} MSB-first onto
// ser_bit over 16 cycles, then emits a one-cycle capture strobe to downstream.
module serial_operand_feeder #(
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic       ser_bit,
  output logic       cap_add,
  output logic       cap_and,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, STROBE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  cmd_t        act_q, act_d;
  cmd_t        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ser_bit_q, ser_bit_d;
  logic        cap_add_q, cap_add_d;
  logic        cap_and_q, cap_and_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  cmd_t        cmd_in;
  logic        accept;
  logic [15:0] shift_data;

  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign cmd_ready = ~pend_vld_q;
  assign accept    = cmd_valid & ~pend_vld_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          act_d   = cmd_in;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          pend_d     = cmd_in;
          pend_vld_d = 1'b1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = STROBE;
      end
      STROBE: begin
        // The slot drains before a new accept can be considered; accept is
        // already masked whenever the slot is full.
        if (pend_vld_q) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
          cnt_d      = 4'd0;
          state_d    = SHIFT;
        end else if (accept) begin
          act_d   = cmd_in;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the
  // state they describe, giving a[7] in the cycle right after acceptance.
  always_comb begin
    shift_data = {act_d.a, act_d.b};
    ser_bit_d  = (state_d == SHIFT) ? shift_data[4'd15 - cnt_d] : IDLE_BIT;
    cap_add_d  = (state_d == STROBE) & act_d.op[0];
    cap_and_d  = (state_d == STROBE) & act_d.op[1];
    done_d     = (state_d == STROBE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too, so an aborted command leaves
      // nothing behind that could leak into a later one.
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ser_bit_q  <= IDLE_BIT;
      cap_add_q  <= 1'b0;
      cap_and_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ser_bit_q  <= ser_bit_d;
      cap_add_q  <= cap_add_d;
      cap_and_q  <= cap_and_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign ser_bit = ser_bit_q;
  assign cap_add = cap_add_q;
  assign cap_and = cap_and_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: a job-schedule model predicts every output
// each cycle; a downstream shift/capture model pins results to literal values.
module tb_serial_operand_feeder;

  localparam logic IDLE_BIT = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;
  logic       ser_bit, cap_add, cap_and, busy, done;

  serial_operand_feeder #(.IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .ser_bit(ser_bit),
    .cap_add(cap_add), .cap_and(cap_and), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Each accepted command becomes a job occupying cycles start..start+16:
  // 16 shift cycles then one strobe cycle. Jobs run back to back in order.
  typedef struct {
    int         acc;
    int         start;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } job_t;

  job_t q[$];
  job_t nj;
  logic acc_now = 1'b0;
  int   acc_cyc = 0;
  int   total_acc = 0;
  int   aborted = 0;
  int   dut_done = 0;

  logic        e_bit, e_add, e_and, e_done, e_busy, e_rdy;
  logic [15:0] e_data;
  int          k;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].start + 16 < cyc) void'(q.pop_front());
    e_bit = IDLE_BIT; e_add = 1'b0; e_and = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
    if (!rst_n) begin
      aborted += q.size();
      q.delete();
    end else begin
      foreach (q[i]) if (q[i].acc < cyc && q[i].start > cyc) e_rdy = 1'b0;
      if (q.size() > 0 && q[0].start <= cyc) begin
        k      = cyc - q[0].start;
        e_busy = 1'b1;
        if (k < 16) begin
          e_data = {q[0].a, q[0].b};
          e_bit  = e_data[15 - k];
        end else begin
          e_add  = q[0].op[0];
          e_and  = q[0].op[1];
          e_done = 1'b1;
        end
      end
    end
    check("ser_bit",   ser_bit,   e_bit);
    check("cap_add",   cap_add,   e_add);
    check("cap_and",   cap_and,   e_and);
    check("done",      done,      e_done);
    check("busy",      busy,      e_busy);
    check("cmd_ready", cmd_ready, e_rdy);
    if (done) dut_done++;
    acc_now = rst_n && cmd_valid && e_rdy;
    if (acc_now) begin
      nj.acc   = cyc;
      nj.start = (q.size() == 0) ? cyc + 1 : q[$].start + 17;
      if (nj.start < cyc + 1) nj.start = cyc + 1;
      nj.a = cmd_a; nj.b = cmd_b; nj.op = cmd_op;
      q.push_back(nj);
      acc_cyc = cyc;
      total_acc++;
    end
  end

  // Downstream shift-compute register: shifts ser_bit in every edge, captures on strobes.
  logic [15:0] ds_sr;
  logic [7:0]  res_add, res_and;
  always @(posedge clk) begin
    if (cap_add) res_add <= ds_sr[15:8] + ds_sr[7:0];
    if (cap_and) res_and <= ds_sr[15:8] & ds_sr[7:0];
    ds_sr <= {ds_sr[14:0], ser_bit};
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      output int acc);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (acc_now) begin
        acc = acc_cyc;
        break;
      end
    end
    if (acc < 0) begin
      errors++;
      $display("FAIL send_timeout cycle=%0d got=no_accept expected=accept", cyc);
    end
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 2'($urandom);
  endtask

  int b0, a1, a2, a3;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    // Valid held high during reset must not be taken.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 8'hAA;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b1;

    // Single add command.
    send(8'h35, 8'h0A, 2'b01, b0);
    wait_until(b0 + 20);
    check("single_add_result", res_add, 8'h3F);

    // And-only capture.
    send(8'hF0, 8'h3C, 2'b10, b0);
    wait_until(b0 + 20);
    check("and_result", res_and, 8'h30);
    check("and_keeps_add", res_add, 8'h3F);

    // Back-to-back with second command offered in cycle 3.
    send(8'h01, 8'h02, 2'b11, b0);
    wait_until(b0 + 3);
    send(8'hFF, 8'h01, 2'b01, a1);
    check("b2b_accept_cycle", a1 - b0, 3);
    wait_until(b0 + 20);
    check("b2b_first_add", res_add, 8'h03);
    check("b2b_first_and", res_and, 8'h00);
    wait_until(b0 + 36);
    check("b2b_second_add_wrap", res_add, 8'h00);

    // Backpressure: third command waits until the slot drains.
    send(8'h12, 8'h34, 2'b01, b0);
    send(8'h56, 8'h78, 2'b10, a1);
    send(8'h9A, 8'hBC, 2'b11, a2);
    check("bp_second_accept", a1 - b0, 1);
    check("bp_third_accept", a2 - b0, 18);
    wait_until(b0 + 60);
    check("bp_last_add", res_add, 8'h56);
    check("bp_last_and", res_and, 8'h98);

    // Reset abort in cycle 9 with a pending command.
    send(8'hC3, 8'h3C, 2'b11, b0);
    send(8'h11, 8'h22, 2'b01, a1);
    wait_until(b0 + 9);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h20, 8'h07, 2'b01, a3);
    check("post_reset_accept", a3 - b0, 10);
    wait_until(a3 + 20);
    check("post_reset_add", res_add, 8'h27);

    // No-capture command.
    send(8'h5A, 8'hA5, 2'b00, b0);
    wait_until(b0 + 20);
    check("nocap_add_unchanged", res_add, 8'h27);

    // Randomized traffic with random gaps.
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom), 8'($urandom), 2'($urandom), a1);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    wait_until(cyc + 40);

    check("done_count", dut_done, total_acc - aborted);
    check("aborted_count", aborted, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
